// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: pipelined Barrett reduction c mod Q, whole-pipe valid/ready stall.
// Define BARRETT_FINAL_SUB_EN to add the final correction stage (output in [0,Q)).
module barrett_reduce_pipe #(
  parameter int Q         = 3329,
  parameter int Q_WIDTH   = 12,
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Q_WIDTH:0]     out_data,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int K    = IN_WIDTH;
  localparam int LOGQ = $clog2(Q + 1) - 1;
  localparam int MU_W = K - LOGQ + 1;
  localparam int PW   = IN_WIDTH + MU_W;
  localparam int RW   = Q_WIDTH + 1;
  localparam logic [63:0] MU64 = (64'd1 << K) / 64'(Q);
  localparam logic [MU_W-1:0] MU = MU64[MU_W-1:0];
  localparam logic [RW-1:0] QR = RW'(Q);

  logic adv;

  logic                 v1;
  logic [PW-1:0]        p1;
  logic [IN_WIDTH-1:0]  c1;
  logic [TAG_WIDTH-1:0] tag1;

  logic                 v2;
  logic [RW-1:0]        t2;
  logic [RW-1:0]        c2;
  logic [TAG_WIDTH-1:0] tag2;

  logic                 v3;
  logic [RW-1:0]        r3;
  logic [TAG_WIDTH-1:0] tag3;

  logic [PW-1:0]        p_next;
  logic [MU_W-1:0]      qh;
  logic [MU_W+RW-1:0]   t_full;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  assign p_next = {{MU_W{1'b0}}, in_data}
                * {{IN_WIDTH{1'b0}}, MU};
  assign qh     = p1[PW-1:K];
  assign t_full = {{RW{1'b0}}, qh}
                * {{MU_W{1'b0}}, QR};

  // Only the quotient estimate and the low residue bits matter downstream.
  logic unused_bits;
  assign unused_bits = ^{p1[K-1:0], c1[IN_WIDTH-1:RW],
                         t_full[MU_W+RW-1:RW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      p1   <= '0;
      c1   <= '0;
      tag1 <= '0;
      v2   <= 1'b0;
      t2   <= '0;
      c2   <= '0;
      tag2 <= '0;
      v3   <= 1'b0;
      r3   <= '0;
      tag3 <= '0;
    end else if (adv) begin
      v1   <= in_valid & in_ready;
      p1   <= p_next;
      c1   <= in_data;
      tag1 <= in_tag;
      v2   <= v1;
      t2   <= t_full[RW-1:0];
      c2   <= c1[RW-1:0];
      tag2 <= tag1;
      v3   <= v2;
      r3   <= c2 - t2;
      tag3 <= tag2;
    end
  end

`ifdef BARRETT_FINAL_SUB_EN
  logic                 v4;
  logic [RW-1:0]        r4;
  logic [TAG_WIDTH-1:0] tag4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4   <= 1'b0;
      r4   <= '0;
      tag4 <= '0;
    end else if (adv) begin
      v4   <= v3;
      r4   <= (r3 >= QR) ? r3 - QR : r3;
      tag4 <= tag3;
    end
  end

  assign out_valid = v4;
  assign out_data  = r4;
  assign out_tag   = tag4;
`else
  assign out_valid = v3;
  assign out_data  = r3;
  assign out_tag   = tag3;
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb_barrett_reduce_pipe: directed and streamed checks of the Barrett reducer.
// Honours BARRETT_FINAL_SUB_EN for latency and exactness of results.
module tb_barrett_reduce_pipe;
`ifdef BARRETT_FINAL_SUB_EN
  localparam int LAT = 4;
  localparam logic [12:0] EXP_MAX  = 13'd1352;
  localparam logic [13:0] EXP_D2   = 14'd7647;
`else
  localparam int LAT = 3;
  localparam logic [12:0] EXP_MAX  = 13'd4681;
  localparam logic [13:0] EXP_D2   = 14'd15328;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic [7:0]  out_tag;

  logic        d2_in_valid;
  logic        d2_in_ready;
  logic [25:0] d2_in_data;
  logic [7:0]  d2_in_tag;
  logic        d2_out_valid;
  logic [13:0] d2_out_data;
  logic [7:0]  d2_out_tag;

  int n_cmp;
  int n_bad;

  barrett_reduce_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  barrett_reduce_pipe #(
    .Q         (7681),
    .Q_WIDTH   (13),
    .IN_WIDTH  (26),
    .TAG_WIDTH (8)
  ) d2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d2_in_valid),
    .in_ready  (d2_in_ready),
    .in_data   (d2_in_data),
    .in_tag    (d2_in_tag),
    .out_valid (d2_out_valid),
    .out_ready (1'b1),
    .out_data  (d2_out_data),
    .out_tag   (d2_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit red_ok(input logic [12:0] got,
                                input logic [31:0] c);
    logic [31:0] m;
    m = c % 32'd3329;
`ifdef BARRETT_FINAL_SUB_EN
    return {19'd0, got} == m;
`else
    return ({19'd0, got} == m) || ({19'd0, got} == m + 32'd3329);
`endif
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 13'd0 || out_tag !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%0b d=%0d t=%0h want 0/0/0",
               out_valid, out_data, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    logic [31:0] cv [3];
    logic        ev;
    cv = '{32'd0, 32'd3328, 32'd3329};
    for (int j = 0; j <= LAT + 4; j++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (j < 3);
      in_tag    = 8'h10 + 8'(j);
      if (j < 3) in_data = cv[j];
      else       in_data = 32'd0;
      @(negedge clk);
      ev = (j >= LAT) && (j < LAT + 3);
      n_cmp++;
      if (out_valid !== ev) begin
        n_bad++;
        $display("FAIL lat_valid j=%0d: got %0b want %0b", j, out_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if (!red_ok(out_data, cv[j-LAT])) begin
          n_bad++;
          $display("FAIL lat_data j=%0d: got %0d want %0d mod Q",
                   j, out_data, cv[j-LAT] % 3329);
        end
        n_cmp++;
        if (out_tag !== 8'h10 + 8'(j - LAT)) begin
          n_bad++;
          $display("FAIL lat_tag j=%0d: got %0h want %0h",
                   j, out_tag, 8'h10 + 8'(j - LAT));
        end
      end
    end
    idle(2);
  endtask

  task automatic test_max();
    bit seen;
    @(posedge clk); #1;
    in_valid    = 1'b1;
    in_data     = 32'hFFFF_FFFF;
    in_tag      = 8'hA5;
    d2_in_valid = 1'b1;
    d2_in_data  = 26'h3FF_FFFF;
    d2_in_tag   = 8'h3C;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    d2_in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (out_data !== EXP_MAX || out_tag !== 8'hA5) begin
          n_bad++;
          $display("FAIL max_data: got %0d/%0h want %0d/a5",
                   out_data, out_tag, EXP_MAX);
        end
        n_cmp++;
        if (d2_out_valid !== 1'b1 || d2_out_data !== EXP_D2 ||
            d2_out_tag !== 8'h3C) begin
          n_bad++;
          $display("FAIL q7681_data: got v=%0b %0d/%0h want 1 %0d/3c",
                   d2_out_valid, d2_out_data, d2_out_tag, EXP_D2);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL max_timeout: got no out_valid want one");
    end
    idle(2);
  endtask

  task automatic test_stall();
    logic [31:0] vals [6];
    int idx;
    int k;
    vals = '{32'd100, 32'd16652, 32'd305419896,
             32'd9999, 32'd6658, 32'd3330};
    idx = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? vals[idx] : 32'd0;
      in_tag    = 8'h40 + 8'(idx);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== !out_valid) begin
        n_bad++;
        $display("FAIL stall_ready j=%0d: got %0b want %0b",
                 j, in_ready, !out_valid);
      end
      if (in_valid && in_ready) idx++;
    end
    n_cmp++;
    if (idx !== LAT || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_accepts: got %0d v=%0b r=%0b want %0d 1 0",
               idx, out_valid, in_ready, LAT);
    end
    k = 0;
    for (int j = 0; j < LAT + 6; j++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (k >= 6 || !red_ok(out_data, vals[k]) ||
            out_tag !== 8'h40 + 8'(k)) begin
          n_bad++;
          $display("FAIL stall_drain k=%0d: got %0d/%0h want %0d/%0h",
                   k, out_data, out_tag, vals[k % 6] % 3329,
                   8'h40 + 8'(k));
        end
        k++;
      end
    end
    n_cmp++;
    if (k !== LAT) begin
      n_bad++;
      $display("FAIL stall_count: got %0d want %0d", k, LAT);
    end
  endtask

  task automatic test_stream();
    logic [39:0] q [$];
    logic [39:0] e;
    logic [31:0] cur_c;
    logic [7:0]  cur_t;
    logic        held;
    logic [12:0] hd;
    logic [7:0]  ht;
    int sent;
    int got;
    sent  = 0;
    got   = 0;
    held  = 1'b0;
    hd    = '0;
    ht    = '0;
    cur_c = $urandom;
    cur_t = 8'h00;
    for (int cyc = 0; cyc < 6000 && (sent < 1000 || q.size() > 0); cyc++) begin
      @(posedge clk); #1;
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 8);
      in_data   = cur_c;
      in_tag    = cur_t;
      out_ready = ($urandom_range(0, 9) >= 3);
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
          n_bad++;
          $display("FAIL stream_hold: got %0b %0d/%0h want 1 %0d/%0h",
                   out_valid, out_data, out_tag, hd, ht);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({cur_t, cur_c});
        sent++;
        cur_c = $urandom;
        cur_t = cur_t + 8'd1;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: got %0d want none", out_data);
        end else begin
          e = q.pop_front();
          if (!red_ok(out_data, e[31:0]) || out_tag !== e[39:32]) begin
            n_bad++;
            $display("FAIL stream_data #%0d: got %0d/%0h want %0d/%0h",
                     got, out_data, out_tag, e[31:0] % 3329, e[39:32]);
          end
        end
        got++;
      end
      held = out_valid && !out_ready;
      hd   = out_data;
      ht   = out_tag;
    end
    n_cmp++;
    if (sent != 1000 || got != 1000 || q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count: got sent=%0d recv=%0d want 1000/1000",
               sent, got);
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    int acc;
    acc = 0;
    for (int j = 0; j < 12 && acc < LAT; j++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'd1234 + 32'(acc);
      in_tag    = 8'h70 + 8'(acc);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 13'd1234 || out_tag !== 8'h70) begin
      n_bad++;
      $display("FAIL flight_full: got %0b %0d/%0h want 1 1234/70",
               out_valid, out_data, out_tag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 13'd0 || out_tag !== 8'd0) begin
      n_bad++;
      $display("FAIL flight_async: got %0b %0d/%0h want 0 0/0",
               out_valid, out_data, out_tag);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flight_stale j=%0d: got %0b want 0", j, out_valid);
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_tag      = '0;
    out_ready   = 1'b1;
    d2_in_valid = 1'b0;
    d2_in_data  = '0;
    d2_in_tag   = '0;
    test_reset();
    test_latency();
    test_max();
    test_stall();
    test_stream();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
